tm1638_key_reader: RTL and testbench

TM1638_KEY_READER -- requirements
Module: tm1638_key_reader

---
 rtl/tm1638_key_reader.sv | 208 ++++++++++++++++++++
 tb/tb_tm1638_key_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_key_reader.sv
// tm1638_key_reader: issues one TM1638 key-scan read (command 0x42, then
// 32 data bits clocked back over the shared DIO line) and presents the four
// received bytes plus the eight decoded button states.
//
// Ports
//   clk_50M  in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request a key-scan read (sampled only in IDLE)
//   busy     out  transaction in progress
//   done     out  one-cycle completion pulse
//   raw      out  received bytes, byte k in raw[8k+7:8k]
//   keys     out  decoded buttons, 1 = pressed
//   tm_clk   out  TM1638 serial clock
//   tm_stb   out  TM1638 strobe, active low
//   dio_out  out  value driven onto DIO
//   dio_oe   out  DIO drive enable (0 = released for the TM1638 to drive)
//   dio_in   in   DIO readback (not synchronised here)
module tm1638_key_reader #(
  parameter int CLK_DIV  = 25,
  parameter int WAIT_CYC = 100
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] raw,
  output logic [7:0]  keys,
  output logic        tm_clk,
  output logic        tm_stb,
  output logic        dio_out,
  output logic        dio_oe,
  input  logic        dio_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_WAIT, S_READ, S_HOLD, S_DONE
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h42;
  localparam logic [9:0] HALF_LAST = 10'(CLK_DIV - 1);
  localparam logic [9:0] WAIT_LAST = 10'(WAIT_CYC - 1);

  state_t      r_state, w_state;
  logic [9:0]  r_cnt, w_cnt;
  logic [4:0]  r_bit, w_bit;
  logic [31:0] r_sh, w_sh;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic [31:0] r_raw, w_raw;
  logic [7:0]  r_keys, w_keys;
  logic        r_tm_clk, w_tm_clk;
  logic        r_tm_stb, w_tm_stb;
  logic        r_dio_out, w_dio_out;
  logic        r_dio_oe, w_dio_oe;
  logic [7:0]  w_dec;
  logic        w_half_end;

  assign busy    = r_busy;
  assign done    = r_done;
  assign raw     = r_raw;
  assign keys    = r_keys;
  assign tm_clk  = r_tm_clk;
  assign tm_stb  = r_tm_stb;
  assign dio_out = r_dio_out;
  assign dio_oe  = r_dio_oe;

  assign w_half_end = (r_cnt == HALF_LAST);

  // Button i (0..3) is bit 0 of byte i; button i+4 is bit 4 of byte i.
  always_comb begin
    w_dec = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_dec[i]     = r_sh[8*i];
      w_dec[i + 4] = r_sh[8*i + 4];
    end
  end

  // Every output is computed here one cycle ahead and registered below, so the
  // pins change on the same edge as the state they belong to.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt + 10'd1;
    w_bit     = r_bit;
    w_sh      = r_sh;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_raw     = r_raw;
    w_keys    = r_keys;
    w_tm_clk  = r_tm_clk;
    w_tm_stb  = r_tm_stb;
    w_dio_out = r_dio_out;
    w_dio_oe  = r_dio_oe;
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (start) begin
          w_state   = S_SETUP;
          w_tm_stb  = 1'b0;
          w_tm_clk  = 1'b1;
          w_dio_oe  = 1'b1;
          w_dio_out = 1'b1;
          w_busy    = 1'b1;
        end
      end
      S_SETUP: begin
        if (w_half_end) begin
          w_state   = S_CMD;
          w_cnt     = '0;
          w_bit     = '0;
          w_tm_clk  = 1'b0;
          w_dio_out = CMD_READ[0];
        end
      end
      S_CMD: begin
        if (w_half_end) begin
          w_cnt = '0;
          if (!r_tm_clk) begin
            w_tm_clk = 1'b1;
          end else if (r_bit == 5'd7) begin
            // Release DIO while tm_clk stays high; the TM1638 owns it next.
            w_state   = S_WAIT;
            w_dio_oe  = 1'b0;
            w_dio_out = 1'b1;
          end else begin
            w_bit     = r_bit + 5'd1;
            w_tm_clk  = 1'b0;
            w_dio_out = CMD_READ[r_bit[2:0] + 3'd1];
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == WAIT_LAST) begin
          w_state  = S_READ;
          w_cnt    = '0;
          w_bit    = '0;
          w_tm_clk = 1'b0;
        end
      end
      S_READ: begin
        if (w_half_end) begin
          w_cnt = '0;
          if (!r_tm_clk) begin
            // Sample on the edge that raises tm_clk; shift right so the
            // first bit ends up in bit 0.
            w_tm_clk = 1'b1;
            w_sh     = {dio_in, r_sh[31:1]};
          end else if (r_bit == 5'd31) begin
            w_state  = S_HOLD;
            w_tm_stb = 1'b1;
          end else begin
            w_bit    = r_bit + 5'd1;
            w_tm_clk = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (w_half_end) begin
          w_state = S_DONE;
          w_cnt   = '0;
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_raw   = r_sh;
          w_keys  = w_dec;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_cnt   = '0;
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_sh      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_raw     <= '0;
      r_keys    <= '0;
      r_tm_clk  <= 1'b1;
      r_tm_stb  <= 1'b1;
      r_dio_out <= 1'b1;
      r_dio_oe  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_bit     <= w_bit;
      r_sh      <= w_sh;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_raw     <= w_raw;
      r_keys    <= w_keys;
      r_tm_clk  <= w_tm_clk;
      r_tm_stb  <= w_tm_stb;
      r_dio_out <= w_dio_out;
      r_dio_oe  <= w_dio_oe;
    end
  end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Bench for tm1638_key_reader: a timeline model derived from the cycle offset
// since start is checked against every output on every falling clock edge,
// a TM1638 model answers on DIO and records the command and read clocking,
// and directed cases pin the model with hand-computed values.
module tb_tm1638_key_reader;

  localparam int D = 2;
  localparam int W = 4;
  localparam int L = 82*D + W;

  logic        clk_50M = 1'b0;
  logic        rst_n, start, dio_in;
  logic        busy, done, tm_clk, tm_stb, dio_out, dio_oe;
  logic [31:0] raw;
  logic [7:0]  keys;

  logic [31:0] tm_data;

  tm1638_key_reader #(.CLK_DIV(D), .WAIT_CYC(W)) dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .raw     (raw),
    .keys    (keys),
    .tm_clk  (tm_clk),
    .tm_stb  (tm_stb),
    .dio_out (dio_out),
    .dio_oe  (dio_oe),
    .dio_in  (dio_in)
  );

  always #5 clk_50M = ~clk_50M;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] decode(input logic [31:0] r);
    logic [7:0] k;
    for (int i = 0; i < 4; i++) begin
      k[i]     = r[8*i];
      k[i + 4] = r[8*i + 4];
    end
    return k;
  endfunction

  // Expected pin values at cycle tt after the accepting edge (0 = idle).
  task automatic model(input int tt, output logic eb, output logic ed, output logic es,
                       output logic ec, output logic eo, output logic ev);
    int u, h;
    logic [7:0] cb;
    cb = 8'h42;
    eb = 0; ed = 0; es = 1; ec = 1; eo = 0; ev = 1;
    if (tt >= 1 && tt <= L) begin
      eb = 1; es = 0; u = tt - 1;
      if (u < D) begin
        eo = 1;
      end else if (u < 17*D) begin
        h = (u - D) / D; ec = h[0]; eo = 1; ev = cb[h/2];
      end else if (u >= 17*D + W && u < 81*D + W) begin
        h = (u - 17*D - W) / D; ec = h[0];
      end else if (u >= 81*D + W) begin
        es = 1;
      end
    end else if (tt == L + 1) begin
      ed = 1;
    end
  endtask

  // Per-cycle compare against the timeline model.
  int          t = 0;
  logic [31:0] exp_raw = '0;
  logic [7:0]  exp_keys = '0;
  logic        e_b, e_d, e_s, e_c, e_o, e_v;

  always @(negedge clk_50M) begin
    if (!rst_n) begin
      t = 0; exp_raw = '0; exp_keys = '0;
    end else if (t == L + 1) begin
      exp_raw = tm_data; exp_keys = decode(tm_data);
    end
    model(t, e_b, e_d, e_s, e_c, e_o, e_v);
    chk("cyc busy",    busy,    e_b);
    chk("cyc done",    done,    e_d);
    chk("cyc tm_stb",  tm_stb,  e_s);
    chk("cyc tm_clk",  tm_clk,  e_c);
    chk("cyc dio_oe",  dio_oe,  e_o);
    chk("cyc dio_out", dio_out, e_v);
    chk("cyc raw",     raw,     exp_raw);
    chk("cyc keys",    keys,    exp_keys);
    if (rst_n) begin
      if (t == 0)      t = start ? 1 : 0;
      else if (t <= L) t = t + 1;
      else             t = 0;
    end
  end

  // TM1638 model and protocol recorder.
  logic       p_clk = 1, p_stb = 1, p_oe = 0, p_do = 1;
  int         cyc = 0;
  int         cmd_bits = 0, hi_bad = 0, rd_rises = 0, rd_falls = 0, rd_idx = 0;
  int         oe_fall_cyc = -1, first_rd_fall_cyc = -1;
  int         stb_run = 0, last_stb_run = 0, done_cnt = 0;
  logic [7:0] cmd_byte = '0;

  always @(negedge clk_50M) begin
    cyc++;
    if (!rst_n) begin
      p_clk = 1; p_stb = 1; p_oe = 0; p_do = 1; stb_run = 0;
    end else begin
      if (!tm_stb && p_stb) begin
        last_stb_run = stb_run; stb_run = 0;
        cmd_bits = 0; cmd_byte = '0; hi_bad = 0;
        rd_rises = 0; rd_falls = 0; rd_idx = 0;
        oe_fall_cyc = -1; first_rd_fall_cyc = -1;
      end
      if (tm_stb) stb_run++;
      if (!p_clk && tm_clk && !tm_stb) begin
        if (dio_oe) begin cmd_byte = {dio_out, cmd_byte[7:1]}; cmd_bits++; end
        else rd_rises++;
      end
      if (p_clk && tm_clk && !tm_stb && dio_oe && dio_out !== p_do) hi_bad++;
      if (p_oe && !dio_oe && oe_fall_cyc < 0) oe_fall_cyc = cyc;
      if (p_clk && !tm_clk && !dio_oe && !tm_stb) begin
        rd_falls++;
        if (first_rd_fall_cyc < 0) first_rd_fall_cyc = cyc;
        if (rd_idx < 32) dio_in = tm_data[rd_idx];
        rd_idx++;
      end
      if (done) done_cnt++;
      p_clk = tm_clk; p_stb = tm_stb; p_oe = dio_oe; p_do = dio_out;
    end
  end

  task automatic tick();
    @(posedge clk_50M); #1;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_done(input string nm, output int bcnt);
    bit seen;
    seen = 0; bcnt = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk_50M);
      if (done) seen = 1;
      else if (busy) bcnt++;
    end
    chk({nm, " done seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int bc, d0;

  initial begin
    rst_n = 0; start = 0; dio_in = 1; tm_data = '0;
    repeat (3) @(posedge clk_50M);
    #1;
    chk("rst tm_clk", tm_clk, 1); chk("rst tm_stb", tm_stb, 1);
    chk("rst dio_oe", dio_oe, 0); chk("rst dio_out", dio_out, 1);
    chk("rst busy", busy, 0);     chk("rst raw", raw, 0);
    rst_n = 1; tick(); tick();

    // Single read with command/turnaround inspection.
    tm_data = 32'h11001001; d0 = done_cnt;
    pulse_start();
    wait_done("A", bc);
    chk("A busy cycles", bc, 168);
    chk("A raw", raw, 32'h11001001);
    chk("A keys", keys, 8'hA9);
    chk("A cmd byte", cmd_byte, 8'h42);
    chk("A cmd bits", cmd_bits, 8);
    chk("A dio stable high", hi_bad, 0);
    chk("A read rises", rd_rises, 32);
    chk("A turnaround", 32'(oe_fall_cyc >= 0 && first_rd_fall_cyc - oe_fall_cyc >= W), 1);
    tick();
    chk("A done pulses", done_cnt - d0, 1);
    chk("A done low", done, 0);

    // Start during a busy transaction is dropped.
    tm_data = 32'h5A3C9612; d0 = done_cnt;
    pulse_start();
    repeat (48) tick();
    pulse_start();
    wait_done("B", bc);
    chk("B raw", raw, 32'h5A3C9612);
    repeat (60) tick();
    chk("B done pulses", done_cnt - d0, 1);
    chk("B idle busy", busy, 0);

    // Start held across three back-to-back reads.
    tm_data = 32'hFFFFFFFF;
    start = 1;
    wait_done("C1", bc);
    chk("C1 keys", keys, 8'hFF);
    #2 tm_data = 32'h00000000;
    wait_done("C2", bc);
    chk("C2 keys", keys, 8'h00);
    chk("C2 stb gap", last_stb_run, D + 2);
    #2 tm_data = 32'h00000010;
    wait_done("C3", bc);
    chk("C3 keys", keys, 8'h10);
    chk("C3 stb gap", last_stb_run, D + 2);
    tick();
    start = 0;
    tick();

    // Reset during READ bit 10 aborts, then a new read completes.
    tm_data = 32'h0F0FA5A5;
    pulse_start();
    for (int i = 0; i < 300 && rd_falls != 11; i++) @(negedge clk_50M);
    chk("D reach bit10", rd_falls, 11);
    #2 rst_n = 0;
    #1;
    chk("D rst tm_stb", tm_stb, 1); chk("D rst dio_oe", dio_oe, 0);
    chk("D rst busy", busy, 0);     chk("D rst raw", raw, 0);
    chk("D rst keys", keys, 0);
    d0 = done_cnt;
    repeat (3) tick();
    rst_n = 1;
    repeat (20) tick();
    chk("D no done", done_cnt - d0, 0);
    pulse_start();
    wait_done("D", bc);
    chk("D raw", raw, 32'h0F0FA5A5);
    chk("D keys", keys, 8'h0F);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
